// File: rtl/frame_draw_scheduler_if.sv
// Tracker-side and display-writer-side signals of the frame draw scheduler.
// The scheduler uses the master modport; the tracker and display writer use the slave modport.
interface frame_draw_scheduler_if;
   logic       scan_en;
   logic [3:0] x;
   logic [3:0] y;
   logic [2:0] obj_code;
   logic       diff;
   logic       draw_valid;
   logic       draw_ready;
   logic [3:0] draw_x;
   logic [3:0] draw_y;
   logic [2:0] draw_code;

   modport master (
      output scan_en, draw_valid, draw_x, draw_y, draw_code,
      input  x, y, obj_code, diff, draw_ready
   );

   modport slave (
      input  scan_en, draw_valid, draw_x, draw_y, draw_code,
      output x, y, obj_code, diff, draw_ready
   );
endinterface

// File: rtl/frame_draw_scheduler.sv
// Runs one tracker scan per start request and queues changed cells in a small FIFO.
// The display writer drains that FIFO through a first-word-fall-through valid/ready handshake.
module frame_draw_scheduler #(
   parameter int GRID_W     = 16,
   parameter int GRID_H     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         start,
   frame_draw_scheduler_if.master       bus,
   output logic                         busy,
   output logic                         frame_done,
   output logic [7:0]                   dirty_count
);

   localparam int CELLS = GRID_W * GRID_H;
   localparam int CNT_W = $clog2(CELLS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(CELLS - 1);
   localparam logic [OCC_W-1:0] FULL      = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cell_cnt;
   logic [10:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [OCC_W-1:0]  fifo_count;
   logic              push;
   logic              pop;

   // The tracker only advances while there is room for the cell it presents.
   assign bus.scan_en    = (state == SCAN) && (fifo_count != FULL);
   assign bus.draw_valid = (fifo_count != '0);
   assign bus.draw_x     = mem[rd_ptr][10:7];
   assign bus.draw_y     = mem[rd_ptr][6:3];
   assign bus.draw_code  = mem[rd_ptr][2:0];

   assign push       = bus.scan_en && bus.diff;
   assign pop        = bus.draw_valid && bus.draw_ready;
   assign busy       = (state == SCAN) || (state == DRAIN);
   assign frame_done = (state == DONE);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         cell_cnt    <= '0;
         dirty_count <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= {bus.x, bus.y, bus.obj_code};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + OCC_W'(1);
            2'b01:   fifo_count <= fifo_count - OCC_W'(1);
            default: fifo_count <= fifo_count;
         endcase

         case (state)
            IDLE: begin
               if (start) begin
                  state       <= SCAN;
                  cell_cnt    <= '0;
                  dirty_count <= '0;
               end
            end
            SCAN: begin
               if (bus.scan_en) begin
                  if (bus.diff) begin
                     dirty_count <= dirty_count + 8'd1;
                  end
                  if (cell_cnt == LAST_CELL) begin
                     cell_cnt <= '0;
                     state    <= DRAIN;
                  end else begin
                     cell_cnt <= cell_cnt + CNT_W'(1);
                  end
               end
            end
            // Finish once the last queued cell leaves, or at once if nothing is queued.
            DRAIN: begin
               if ((fifo_count == '0) || (pop && (fifo_count == OCC_W'(1)))) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: a behavioural 16x12 tracker feeds directed dirty maps,
// and a monitor records every accepted draw for comparison against hand-computed vectors.
module tb_frame_draw_scheduler;

   typedef struct {
      int                nDirty;
      logic [5:0][7:0]   cells;
      logic [5:0][2:0]   codes;
      int                expDirty;
      int                expScan;
   } vec_t;

   logic       clk = 1'b0;
   logic       nrst;
   logic       start;
   logic       busy;
   logic       frame_done;
   logic [7:0] dirty_count;

   frame_draw_scheduler_if bus();

   frame_draw_scheduler dut (
      .clk         (clk),
      .nrst        (nrst),
      .start       (start),
      .bus         (bus),
      .busy        (busy),
      .frame_done  (frame_done),
      .dirty_count (dirty_count)
   );

   always #5 clk = ~clk;

   int          passCount = 0;
   int          checkCount = 0;
   logic        diffMap [192];
   logic [2:0]  codeMap [192];
   int          idx = 0;
   bit          adv;
   int          scanTotal = 0;
   int          validTotal = 0;
   int          doneTotal = 0;
   logic [10:0] drawQ [$];
   int          scanBase;
   int          validBase;
   int          doneBase;
   int          drawBase;
   vec_t        vecs [3];
   vec_t        bpVec;
   vec_t        drainVec;
   vec_t        intVec;

   // The tracker holds its cell unless scan_en was high at the edge; inputs change 1 after the edge.
   always @(posedge clk) begin
      adv = bus.scan_en;
      #1;
      if (!nrst) idx = 0;
      else if (adv) idx = (idx == 191) ? 0 : idx + 1;
      bus.x        = 4'(idx % 16);
      bus.y        = 4'(idx / 16);
      bus.diff     = diffMap[idx];
      bus.obj_code = codeMap[idx];
   end

   always @(negedge clk) begin
      if (bus.scan_en) scanTotal++;
      if (bus.draw_valid) validTotal++;
      if (frame_done) doneTotal++;
      if (bus.draw_valid && bus.draw_ready)
         drawQ.push_back({bus.draw_x, bus.draw_y, bus.draw_code});
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic markBases();
      scanBase  = scanTotal;
      validBase = validTotal;
      doneBase  = doneTotal;
      drawBase  = drawQ.size();
   endtask

   task automatic loadMap(input vec_t v);
      for (int i = 0; i < 192; i++) begin
         diffMap[i] = 1'b0;
         codeMap[i] = 3'(i % 5);
      end
      for (int j = 0; j < v.nDirty; j++) begin
         diffMap[v.cells[j]] = 1'b1;
         codeMap[v.cells[j]] = v.codes[j];
      end
   endtask

   task automatic applyStimulus(input vec_t v, input logic ready);
      loadMap(v);
      bus.draw_ready = ready;
      markBases();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input int maxCycles);
      int n = 0;
      while (frame_done !== 1'b1 && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput("frameDoneSeen", int'(frame_done), 1);
      tick();
   endtask

   task automatic checkDraws(input vec_t v, input string tag);
      int got = drawQ.size() - drawBase;
      logic [10:0] expEntry;
      checkOutput({tag, "_drawCount"}, got, v.nDirty);
      for (int j = 0; j < v.nDirty; j++) begin
         if (j < got) begin
            expEntry = {4'(int'(v.cells[j]) % 16), 4'(int'(v.cells[j]) / 16), v.codes[j]};
            checkOutput($sformatf("%s_draw%0d", tag, j), int'(drawQ[drawBase + j]), int'(expEntry));
         end
      end
   endtask

   initial begin
      nrst = 1'b0;
      start = 1'b0;
      bus.draw_ready = 1'b0;

      vecs[0] = '{nDirty: 0, cells: '0, codes: '0, expDirty: 0, expScan: 192};
      vecs[1] = '{nDirty: 4, cells: '0, codes: '0, expDirty: 4, expScan: 192};
      vecs[1].cells[0] = 8'd68;  vecs[1].codes[0] = 3'd2;
      vecs[1].cells[1] = 8'd69;  vecs[1].codes[1] = 3'd1;
      vecs[1].cells[2] = 8'd70;  vecs[1].codes[2] = 3'd0;
      vecs[1].cells[3] = 8'd71;  vecs[1].codes[3] = 3'd3;
      vecs[2] = '{nDirty: 5, cells: '0, codes: '0, expDirty: 5, expScan: 192};
      vecs[2].cells[0] = 8'd0;   vecs[2].codes[0] = 3'd4;
      vecs[2].cells[1] = 8'd15;  vecs[2].codes[1] = 3'd3;
      vecs[2].cells[2] = 8'd16;  vecs[2].codes[2] = 3'd1;
      vecs[2].cells[3] = 8'd100; vecs[2].codes[3] = 3'd2;
      vecs[2].cells[4] = 8'd191; vecs[2].codes[4] = 3'd4;

      bpVec = '{nDirty: 6, cells: '0, codes: '0, expDirty: 6, expScan: 192};
      for (int j = 0; j < 6; j++) bpVec.cells[j] = 8'(20 + j);
      bpVec.codes[0] = 3'd1; bpVec.codes[1] = 3'd2; bpVec.codes[2] = 3'd3;
      bpVec.codes[3] = 3'd0; bpVec.codes[4] = 3'd4; bpVec.codes[5] = 3'd2;

      drainVec = '{nDirty: 1, cells: '0, codes: '0, expDirty: 1, expScan: 192};
      drainVec.cells[0] = 8'd191; drainVec.codes[0] = 3'd4;

      intVec = '{nDirty: 2, cells: '0, codes: '0, expDirty: 2, expScan: 192};
      intVec.cells[0] = 8'd10; intVec.codes[0] = 3'd1;
      intVec.cells[1] = 8'd60; intVec.codes[1] = 3'd2;

      loadMap(vecs[0]);

      repeat (2) @(negedge clk);
      checkOutput("rst_scan_en", int'(bus.scan_en), 0);
      checkOutput("rst_draw_valid", int'(bus.draw_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_frame_done", int'(frame_done), 0);
      checkOutput("rst_dirty_count", int'(dirty_count), 0);
      checkOutput("rst_draw_x", int'(bus.draw_x), 0);
      checkOutput("rst_draw_y", int'(bus.draw_y), 0);
      checkOutput("rst_draw_code", int'(bus.draw_code), 0);

      tick();
      nrst = 1'b1;
      markBases();
      repeat (100) tick();
      checkOutput("idle_scanCycles", scanTotal - scanBase, 0);
      checkOutput("idle_validCycles", validTotal - validBase, 0);
      checkOutput("idle_doneCount", doneTotal - doneBase, 0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_dirty_count", int'(dirty_count), 0);

      for (int r = 0; r < 3; r++) begin
         applyStimulus(vecs[r], 1'b1);
         waitDone(196);
         checkOutput($sformatf("row%0d_scanCycles", r), scanTotal - scanBase, vecs[r].expScan);
         checkOutput($sformatf("row%0d_doneCount", r), doneTotal - doneBase, 1);
         checkOutput($sformatf("row%0d_dirty_count", r), int'(dirty_count), vecs[r].expDirty);
         checkOutput($sformatf("row%0d_validCycles", r), validTotal - validBase, vecs[r].nDirty);
         checkOutput($sformatf("row%0d_busy", r), int'(busy), 0);
         checkDraws(vecs[r], $sformatf("row%0d", r));
      end

      // Back-pressure: four captures fill the FIFO and freeze the tracker on cell 24 = (8,1).
      begin
         int n = 0;
         applyStimulus(bpVec, 1'b0);
         while (!(busy && !bus.scan_en) && n < 100) begin
            @(negedge clk);
            n++;
         end
         checkOutput("bp_stallReached", int'(busy && !bus.scan_en), 1);
         checkOutput("bp_dirty_at_stall", int'(dirty_count), 4);
         checkOutput("bp_scan_at_stall", scanTotal - scanBase, 24);
         checkOutput("bp_head", int'({bus.draw_x, bus.draw_y, bus.draw_code}), int'({4'd4, 4'd1, 3'd1}));
         repeat (3) @(negedge clk);
         checkOutput("bp_x_held", int'(bus.x), 8);
         checkOutput("bp_y_held", int'(bus.y), 1);
         checkOutput("bp_scan_held", scanTotal - scanBase, 24);
         tick();
         bus.draw_ready = 1'b1;
         @(negedge clk);
         checkOutput("bp_scan_en_before_pop", int'(bus.scan_en), 0);
         @(negedge clk);
         checkOutput("bp_scan_en_after_pop", int'(bus.scan_en), 1);
         waitDone(400);
         checkOutput("bp_scanCycles", scanTotal - scanBase, 192);
         checkOutput("bp_doneCount", doneTotal - doneBase, 1);
         checkOutput("bp_dirty_count", int'(dirty_count), 6);
         checkDraws(bpVec, "bp");
      end

      // Last cell dirty with the writer stalled: the frame must sit in DRAIN.
      begin
         int n = 0;
         int busyCycles = 0;
         applyStimulus(drainVec, 1'b0);
         while (scanTotal - scanBase < 192 && n < 300) begin
            @(negedge clk);
            n++;
         end
         tick();
         repeat (10) begin
            @(negedge clk);
            if (busy) busyCycles++;
         end
         checkOutput("drain_scanCycles", scanTotal - scanBase, 192);
         checkOutput("drain_busyCycles", busyCycles, 10);
         checkOutput("drain_noDone", doneTotal - doneBase, 0);
         checkOutput("drain_scan_en", int'(bus.scan_en), 0);
         checkOutput("drain_valid", int'(bus.draw_valid), 1);
         checkOutput("drain_head", int'({bus.draw_x, bus.draw_y, bus.draw_code}), int'({4'd15, 4'd11, 3'd4}));
         tick();
         bus.draw_ready = 1'b1;
         waitDone(10);
         checkOutput("drain_doneCount", doneTotal - doneBase, 1);
         checkOutput("drain_dirty_count", int'(dirty_count), 1);
         checkDraws(drainVec, "drain");
      end

      // A start mid-scan is ignored; reset at cell 100 wipes everything asynchronously.
      begin
         int n = 0;
         applyStimulus(intVec, 1'b1);
         while (idx != 50 && n < 300) begin
            @(negedge clk);
            n++;
         end
         checkOutput("int_reachCell50", idx, 50);
         tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         n = 0;
         while (idx != 100 && n < 300) begin
            @(negedge clk);
            n++;
         end
         checkOutput("int_reachCell100", idx, 100);
         checkOutput("int_busy_mid", int'(busy), 1);
         checkOutput("int_dirty_mid", int'(dirty_count), 2);
         #2;
         nrst = 1'b0;
         #1;
         checkOutput("int_rst_scan_en", int'(bus.scan_en), 0);
         checkOutput("int_rst_busy", int'(busy), 0);
         checkOutput("int_rst_dirty", int'(dirty_count), 0);
         checkOutput("int_rst_valid", int'(bus.draw_valid), 0);
         checkOutput("int_rst_frame_done", int'(frame_done), 0);
         tick();
         tick();
         nrst = 1'b1;
         tick();
         applyStimulus(vecs[0], 1'b1);
         waitDone(196);
         checkOutput("int_new_scanCycles", scanTotal - scanBase, 192);
         checkOutput("int_new_doneCount", doneTotal - doneBase, 1);
         checkOutput("int_new_dirty", int'(dirty_count), 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
